// File: rtl/pe_wb_drain.sv
// Writeback drain controller for one column of N PE accumulators.
// Pops DEPTH entries from the PEs with out_ready, captures each registered pe_sum
// one cycle later, and streams every capture as one N-lane beat over valid/ready.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   start           begins a drain (ignored while busy)
//   busy, done      drain in progress, one-cycle completion pulse
//   wben, out_ready writeback enable and pop strobe broadcast to the PEs
//   pe_sum          concatenated PE out_sum values, lane i from row i
//   m_valid/m_ready output beat handshake
//   m_data, m_idx   beat payload and accumulator entry index
//   m_last          high with the beat for entry DEPTH-1
module pe_wb_drain #(
    parameter int unsigned N          = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              wben,
    output logic              out_ready,
    input  logic [32*N-1:0]   pe_sum,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [32*N-1:0]   m_data,
    output logic [IdxW-1:0]   m_idx,
    output logic              m_last
);

    localparam int unsigned IssW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned MemD = 2 ** PtrW;

    localparam logic [IssW-1:0] IssMax  = IssW'(DEPTH);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DEPTH - 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StDrain, StFlush, StDone} state_e;

    state_e            state_q, state_d;
    logic [IssW-1:0]   issued_q, issued_d;
    logic [IdxW-1:0]   cap_idx_q, cap_idx_d;
    logic              cap_v_q;

    logic [32*N-1:0]   mem_data_q [MemD];
    logic [IdxW-1:0]   mem_idx_q  [MemD];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;

    logic              push, pop, credit_ok;
    logic [CntW-1:0]   count_after;

    assign m_valid = (count_q != '0);
    assign m_data  = mem_data_q[rd_ptr_q];
    assign m_idx   = mem_idx_q[rd_ptr_q];
    assign m_last  = m_valid && (m_idx == IdxLast);

    always_comb begin
        push        = cap_v_q;
        pop         = m_valid && m_ready;
        count_after = count_q - CntW'(pop);
        // A pop is only issued if its capture, plus any capture already in
        // flight, still fits after this cycle's downstream pop.
        credit_ok   = (32'(count_after) + 32'(cap_v_q) + 32'd1) <= FIFO_DEPTH;

        state_d   = state_q;
        issued_d  = issued_q;
        cap_idx_d = cap_idx_q;
        out_ready = 1'b0;
        wben      = 1'b0;
        done      = 1'b0;
        busy      = (state_q != StIdle);

        if (push) begin
            cap_idx_d = (cap_idx_q == IdxLast) ? '0 : cap_idx_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StDrain;
                    issued_d  = '0;
                    cap_idx_d = '0;
                end
            end
            StDrain: begin
                wben      = 1'b1;
                out_ready = (issued_q != IssMax) && credit_ok;
                if (out_ready) begin
                    issued_d = issued_q + 1'b1;
                end
                if (issued_d == IssMax) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                wben = 1'b1;
                // With every pop issued, an empty pipe means every beat was accepted.
                if (!cap_v_q && (count_after == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            issued_q  <= '0;
            cap_idx_q <= '0;
            cap_v_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            issued_q  <= issued_d;
            cap_idx_q <= cap_idx_d;
            // The PE registers its entry on the out_ready edge, so pe_sum is valid next cycle.
            cap_v_q   <= out_ready;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MemD; i++) begin
                mem_data_q[i] <= '0;
                mem_idx_q[i]  <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= pe_sum;
                mem_idx_q[wr_ptr_q]  <= cap_idx_q;
                wr_ptr_q             <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

endmodule

// File: tb/tb_pe_wb_drain.sv
module tb_pe_wb_drain;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [32*N-1:0] data;
        logic [1:0]      idx;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    // main DUT, FIFO_DEPTH = 2
    logic              start, busy, done, wben, out_ready, m_valid, m_ready, m_last;
    logic [32*N-1:0]   pe_sum = '1;
    logic [32*N-1:0]   m_data;
    logic [1:0]        m_idx;
    // second DUT, FIFO_DEPTH = 1
    logic              start1, busy1, done1, wben1, or1, mv1, m_ready1, ml1;
    logic [32*N-1:0]   pe_sum1 = '1;
    logic [32*N-1:0]   md1;
    logic [1:0]        mi1;

    logic rand_ready, ready_force, rnd_bit;
    assign m_ready = rand_ready ? rnd_bit : ready_force;

    int    checks, passes;
    beat_t sb[$];

    pe_wb_drain #(.N(N), .DEPTH(DEPTH), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .wben(wben),
        .out_ready(out_ready), .pe_sum(pe_sum), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_idx(m_idx), .m_last(m_last)
    );

    pe_wb_drain #(.N(N), .DEPTH(DEPTH), .FIFO_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .wben(wben1),
        .out_ready(or1), .pe_sum(pe_sum1), .m_valid(mv1), .m_ready(m_ready1),
        .m_data(md1), .m_idx(mi1), .m_last(ml1)
    );

    function automatic logic [32*N-1:0] beat_data(input logic [7:0] tg, input int e);
        logic [32*N-1:0] d;
        for (int i = 0; i < N; i++) d[32*i +: 32] = {tg, 8'(i), 16'(e)};
        return d;
    endfunction

    // PE column models: register the next entry on each wben && out_ready edge
    logic [7:0] tag;
    logic       pe_clr, pe1_clr;
    int         pe_ptr, pe1_ptr;
    always @(posedge clk) begin
        if (pe_clr) pe_ptr <= 0;
        else if (wben && out_ready) begin
            pe_sum <= beat_data(tag, pe_ptr);
            pe_ptr <= pe_ptr + 1;
        end
    end
    always @(posedge clk) begin
        if (pe1_clr) pe1_ptr <= 0;
        else if (wben1 && or1) begin
            pe_sum1 <= beat_data(8'hF1, pe1_ptr);
            pe1_ptr <= pe1_ptr + 1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 rnd_bit = 1'($urandom_range(0, 1));
        end
    end

    // Monitor for the main DUT: scoreboard, stall stability, credit bound, pops per drain
    int              mon_pops, mon_accs;
    logic            prev_stall;
    logic [32*N-1:0] prev_data;
    logic [1:0]      prev_idx;
    beat_t           mon_e;
    initial begin
        mon_pops = 0; mon_accs = 0; prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                mon_pops = 0; mon_accs = 0; prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (m_valid !== 1'b1 || m_data !== prev_data || m_idx !== prev_idx)
                        $display("FAIL stall_hold: valid=%b idx=%0d data=%h, required valid=1 idx=%0d data=%h",
                                 m_valid, m_idx, m_data, prev_idx, prev_data);
                    else passes++;
                end
                if (out_ready === 1'b1) mon_pops++;
                if (m_valid === 1'b1 && m_ready === 1'b1) begin
                    mon_accs++;
                    checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL unexpected_beat: idx=%0d data=%h, none expected", m_idx, m_data);
                    end else begin
                        mon_e = sb.pop_front();
                        if (m_data !== mon_e.data || m_idx !== mon_e.idx || m_last !== (mon_e.idx == 2'd3))
                            $display("FAIL beat: idx=%0d last=%b data=%h, required idx=%0d last=%b data=%h",
                                     m_idx, m_last, m_data, mon_e.idx, (mon_e.idx == 2'd3), mon_e.data);
                        else passes++;
                    end
                end
                if (busy === 1'b1) begin
                    checks++;
                    if (mon_pops - mon_accs > 2)
                        $display("FAIL outstanding: %0d pops outstanding, required at most 2",
                                 mon_pops - mon_accs);
                    else passes++;
                end
                if (done === 1'b1) begin
                    checks++;
                    if (mon_pops != DEPTH || sb.size() != 0)
                        $display("FAIL drain_pops: pops=%0d left=%0d, required pops=%0d left=0",
                                 mon_pops, sb.size(), DEPTH);
                    else passes++;
                    mon_pops = 0; mon_accs = 0;
                end
                prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
                prev_data  = m_data;
                prev_idx   = m_idx;
            end
        end
    end

    // Pulses start in cycle T and returns during cycle T+1 (1 time unit after the edge)
    task automatic do_start();
        beat_t b;
        @(posedge clk); #1;
        start  = 1'b1;
        pe_clr = 1'b1;
        tag    = tag + 8'd1;
        for (int e = 0; e < DEPTH; e++) begin
            b.data = beat_data(tag, e);
            b.idx  = 2'(e);
            sb.push_back(b);
        end
        @(posedge clk); #1;
        start  = 1'b0;
        pe_clr = 1'b0;
    endtask

    task automatic wait_done();
        bit found = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin found = 1; break; end
        end
        checks++;
        if (!found) $display("FAIL done_timeout: no done within 300 cycles, required done");
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; start1 = 1'b0; m_ready1 = 1'b1;
        rand_ready = 1'b0; ready_force = 1'b1; pe_clr = 1'b0; pe1_clr = 1'b0; tag = 8'h00;
        #12;
        checks++;
        if ({busy, done, wben, out_ready, m_valid, m_last} !== 6'b0)
            $display("FAIL reset_ctrl: busy/done/wben/out_ready/m_valid/m_last=%b, required 000000",
                     {busy, done, wben, out_ready, m_valid, m_last});
        else passes++;
        checks++;
        if (m_data !== '0 || m_idx !== 2'd0)
            $display("FAIL reset_data: data=%h idx=%0d, required 0", m_data, m_idx);
        else passes++;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_basic();
        bit exp_or, exp_mv;
        do_start();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_or = (k >= 1 && k <= 4);
            exp_mv = (k >= 3 && k <= 6);
            checks++;
            if (out_ready !== exp_or || m_valid !== exp_mv || done !== (k == 7))
                $display("FAIL basic_timing T+%0d: out_ready=%b m_valid=%b done=%b, required %b %b %b",
                         k, out_ready, m_valid, done, exp_or, exp_mv, (k == 7));
            else passes++;
            if (k <= 6 || k == 8) begin
                checks++;
                if (busy !== (k <= 6) || wben !== (k <= 6))
                    $display("FAIL basic_busy T+%0d: busy=%b wben=%b, required %b", k, busy, wben, (k <= 6));
                else passes++;
            end
        end
    endtask

    task automatic test_backpressure();
        do_start();
        for (int k = 1; k <= 9; k++) begin
            ready_force = (k < 3 || k > 8);
            @(posedge clk); #1;
        end
        wait_done();
        ready_force = 1'b1;
    endtask

    task automatic test_start_ignored();
        bit found = 0;
        do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin found = 1; break; end
        end
        checks++;
        if (!found) $display("FAIL ignored_done: no done, required done");
        else passes++;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || out_ready !== 1'b0 || wben !== 1'b0)
                $display("FAIL start_in_done: busy=%b out_ready=%b wben=%b, required 000",
                         busy, out_ready, wben);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({wben, out_ready, m_valid, busy} !== 4'b0)
            $display("FAIL reset_mid: wben/out_ready/m_valid/busy=%b, required 0000",
                     {wben, out_ready, m_valid, busy});
        else passes++;
        sb.delete();
        @(posedge clk); #1 rst = 1'b1;
        do_start();
        wait_done();
    endtask

    task automatic test_fifo_depth1();
        beat_t q1[$];
        beat_t b;
        bit    prev_or = 0, fin = 0;
        int    got = 0, pops = 0;
        @(posedge clk); #1;
        start1 = 1'b1; pe1_clr = 1'b1;
        for (int e = 0; e < DEPTH; e++) begin
            b.data = beat_data(8'hF1, e);
            b.idx  = 2'(e);
            q1.push_back(b);
        end
        @(posedge clk); #1;
        start1 = 1'b0; pe1_clr = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (or1 === 1'b1) begin
                pops++;
                checks++;
                if (prev_or) $display("FAIL fd1_spacing: out_ready high in consecutive cycles, required gap");
                else passes++;
            end
            prev_or = (or1 === 1'b1);
            if (mv1 === 1'b1 && m_ready1 === 1'b1) begin
                got++;
                checks++;
                if (q1.size() == 0) begin
                    $display("FAIL fd1_extra: idx=%0d, none expected", mi1);
                end else begin
                    b = q1.pop_front();
                    if (md1 !== b.data || mi1 !== b.idx || ml1 !== (b.idx == 2'd3))
                        $display("FAIL fd1_beat: idx=%0d data=%h, required idx=%0d data=%h",
                                 mi1, md1, b.idx, b.data);
                    else passes++;
                end
            end
            if (done1 === 1'b1) fin = 1;
        end
        checks++;
        if (!fin || got != DEPTH || pops != DEPTH)
            $display("FAIL fd1_count: done=%b beats=%0d pops=%0d, required done=1 beats=%0d pops=%0d",
                     fin, got, pops, DEPTH, DEPTH);
        else passes++;
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int d = 0; d < 1000; d++) begin
            do_start();
            wait_done();
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_fifo_depth1();
        test_random();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
